// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb object: FSM states, bomb square size,
// default fuse/blast durations and the grid-snap helper used at placement.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BLAST = 2'd2
  } bomb_state_t;

  localparam int OBJECT_SIZE          = 32;
  localparam int FUSE_FRAMES_DEFAULT  = 120;
  localparam int BLAST_FRAMES_DEFAULT = 30;
  localparam int COUNT_W              = 10;

  // Round the player's top-left to the nearest 32-pixel grid cell.
  // The 11-bit add wraps on purpose.
  function automatic logic [10:0] snap_to_grid(input logic [10:0] pos);
    logic [10:0] centred;
    centred = pos + 11'(OBJECT_SIZE / 2);
    return {centred[10:5], 5'b0};
  endfunction

endpackage

// File: rtl/bomb_frame_counter.sv
// Loadable down-counter stepped once per video frame, with a zero flag.
// Load wins over the decrement. The count holds at zero.
module bomb_frame_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         is_zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count   = count_reg;
  assign is_zero = (count_reg == '0);

endmodule

// File: rtl/bomb_object.sv
// Single bomb: placed on the player's grid cell, burns a frame fuse, then blasts.
// Optional macro BOMB_BLINK_EN blinks the bomb during the last 32 fuse frames.
module bomb_object
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES  = FUSE_FRAMES_DEFAULT,
  parameter int BLAST_FRAMES = BLAST_FRAMES_DEFAULT
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] playerX,
  input  logic [10:0] playerY,
  input  logic        placeReq,
  input  logic        chainTrigger,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        bombActive,
  output logic        blastActive,
  output logic [10:0] blastX,
  output logic [10:0] blastY,
  output logic        explodePulse
);

  localparam logic [COUNT_W-1:0] FUSE_LOAD  = COUNT_W'(FUSE_FRAMES - 1);
  localparam logic [COUNT_W-1:0] BLAST_LOAD = COUNT_W'(BLAST_FRAMES - 1);

  bomb_state_t        state_reg, state_next;
  logic               cnt_load;
  logic [COUNT_W-1:0] cnt_load_value;
  logic [COUNT_W-1:0] fuse_count;
  logic               cnt_zero;
  logic               latch_bomb;
  logic               explode_next;

  logic [10:0] bomb_x_reg, bomb_y_reg;
  logic [10:0] blast_x_reg, blast_y_reg;
  logic        explode_pulse_reg;
  logic        inside_reg, inside_next;
  logic [10:0] offset_x_reg, offset_x_next;
  logic [10:0] offset_y_reg, offset_y_next;
  logic        blink_hidden;

  // One counter serves as the fuse while ARMED and the blast timer while BLAST.
  bomb_frame_counter #(.W(COUNT_W)) u_frame_counter (
    .clk        (clk),
    .resetN     (resetN),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (startOfFrame),
    .count      (fuse_count),
    .is_zero    (cnt_zero)
  );

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    latch_bomb     = 1'b0;
    explode_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (placeReq) begin
          state_next     = ARMED;
          cnt_load       = 1'b1;
          cnt_load_value = FUSE_LOAD;
          latch_bomb     = 1'b1;
        end
      end
      ARMED: begin
        // A chain hit and a natural expiry on the same edge collapse into one explosion.
        if (chainTrigger || (startOfFrame && cnt_zero)) begin
          state_next     = BLAST;
          cnt_load       = 1'b1;
          cnt_load_value = BLAST_LOAD;
          explode_next   = 1'b1;
        end
      end
      BLAST: begin
        if (startOfFrame && cnt_zero) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef BOMB_BLINK_EN
  logic [2:0] frame_cnt_reg;

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      frame_cnt_reg <= '0;
    end else if (startOfFrame) begin
      frame_cnt_reg <= frame_cnt_reg + 3'd1;
    end
  end

  assign blink_hidden = (fuse_count < COUNT_W'(OBJECT_SIZE)) && frame_cnt_reg[2];
`else
  logic unused_fuse_count;
  assign unused_fuse_count = ^fuse_count;
  assign blink_hidden      = 1'b0;
`endif

  // 12-bit compare keeps bomb_x + 32 from wrapping at the right screen edge.
  always_comb begin
    logic [11:0] px_ext, py_ext, bx_ext, by_ext;
    logic        in_square;
    px_ext    = {1'b0, pixelX};
    py_ext    = {1'b0, pixelY};
    bx_ext    = {1'b0, bomb_x_reg};
    by_ext    = {1'b0, bomb_y_reg};
    in_square = (state_reg == ARMED)
             && (px_ext >= bx_ext) && (px_ext < bx_ext + 12'(OBJECT_SIZE))
             && (py_ext >= by_ext) && (py_ext < by_ext + 12'(OBJECT_SIZE));
    inside_next   = in_square && !blink_hidden;
    offset_x_next = inside_next ? (pixelX - bomb_x_reg) : 11'd0;
    offset_y_next = inside_next ? (pixelY - bomb_y_reg) : 11'd0;
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      bomb_x_reg        <= '0;
      bomb_y_reg        <= '0;
      blast_x_reg       <= '0;
      blast_y_reg       <= '0;
      explode_pulse_reg <= 1'b0;
      inside_reg        <= 1'b0;
      offset_x_reg      <= '0;
      offset_y_reg      <= '0;
    end else begin
      if (latch_bomb) begin
        bomb_x_reg <= snap_to_grid(playerX);
        bomb_y_reg <= snap_to_grid(playerY);
      end
      if (explode_next) begin
        blast_x_reg <= bomb_x_reg;
        blast_y_reg <= bomb_y_reg;
      end
      explode_pulse_reg <= explode_next;
      inside_reg        <= inside_next;
      offset_x_reg      <= offset_x_next;
      offset_y_reg      <= offset_y_next;
    end
  end

  assign bombActive      = (state_reg == ARMED);
  assign blastActive     = (state_reg == BLAST);
  assign blastX          = blast_x_reg;
  assign blastY          = blast_y_reg;
  assign explodePulse    = explode_pulse_reg;
  assign InsideRectangle = inside_reg;
  assign offsetX         = offset_x_reg;
  assign offsetY         = offset_y_reg;

endmodule

// File: tb/tb_bomb_object.sv
// Bench for bomb_object: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a frames-left model of the bomb's life cycle.
module tb_bomb_object;

  localparam int FUSE  = 60;
  localparam int BLAST = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic [10:0] playerX = '0, playerY = '0;
  logic        placeReq = 1'b0, chainTrigger = 1'b0;
  logic [10:0] offsetX, offsetY, blastX, blastY;
  logic        InsideRectangle, bombActive, blastActive, explodePulse;

  always #5 clk = ~clk;

  bomb_object #(.FUSE_FRAMES(FUSE), .BLAST_FRAMES(BLAST)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .playerX         (playerX),
    .playerY         (playerY),
    .placeReq        (placeReq),
    .chainTrigger    (chainTrigger),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .bombActive      (bombActive),
    .blastActive     (blastActive),
    .blastX          (blastX),
    .blastY          (blastY),
    .explodePulse    (explodePulse)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a bomb lives for m_left remaining frames; fuse register == m_left-1.
  localparam int S_IDLE = 0, S_ARMED = 1, S_BLAST = 2;
  int m_state = S_IDLE, m_left = 0, m_sofs = 0;
  int m_bx = 0, m_by = 0, m_blx = 0, m_bly = 0, m_offx = 0, m_offy = 0;
  bit m_explode = 1'b0, m_inside = 1'b0;

  function automatic bit model_hidden();
`ifdef BOMB_BLINK_EN
    return (m_left <= 32) && (((m_sofs / 4) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int snap(input int p);
    return (((p + 16) % 2048) / 32) * 32;
  endfunction

  always @(posedge clk or posedge resetN) begin
    if (resetN) begin
      m_state <= S_IDLE; m_left <= 0; m_sofs <= 0;
      m_bx <= 0; m_by <= 0; m_blx <= 0; m_bly <= 0;
      m_explode <= 1'b0; m_inside <= 1'b0; m_offx <= 0; m_offy <= 0;
    end else begin
      if (startOfFrame) m_sofs <= m_sofs + 1;
      m_explode <= 1'b0;
      if (m_state == S_ARMED && !model_hidden()
          && int'(pixelX) >= m_bx && int'(pixelX) < m_bx + 32
          && int'(pixelY) >= m_by && int'(pixelY) < m_by + 32) begin
        m_inside <= 1'b1;
        m_offx   <= int'(pixelX) - m_bx;
        m_offy   <= int'(pixelY) - m_by;
      end else begin
        m_inside <= 1'b0; m_offx <= 0; m_offy <= 0;
      end
      case (m_state)
        S_IDLE: if (placeReq) begin
          m_state <= S_ARMED; m_left <= FUSE;
          m_bx <= snap(int'(playerX)); m_by <= snap(int'(playerY));
        end
        S_ARMED: begin
          if (chainTrigger || (startOfFrame && m_left == 1)) begin
            m_state <= S_BLAST; m_left <= BLAST; m_explode <= 1'b1;
            m_blx <= m_bx; m_bly <= m_by;
          end else if (startOfFrame) begin
            m_left <= m_left - 1;
          end
        end
        default: if (startOfFrame) begin
          if (m_left == 1) begin m_state <= S_IDLE; m_left <= 0; end
          else m_left <= m_left - 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_inside", InsideRectangle, m_inside);
      check("cmp_offx", offsetX, m_offx);
      check("cmp_offy", offsetY, m_offy);
      check("cmp_bomb_active", bombActive, m_state == S_ARMED);
      check("cmp_blast_active", blastActive, m_state == S_BLAST);
      check("cmp_explode", explodePulse, m_explode);
      if (m_state == S_BLAST) begin
        check("cmp_blast_x", blastX, m_blx);
        check("cmp_blast_y", blastY, m_bly);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sof_cycle();
    startOfFrame = 1'b1;
    cycle();
    startOfFrame = 1'b0;
  endtask

  int n;
  bit seen;

  initial begin
    cycle(); cycle();
    check("reset_bomb_active", bombActive, 0);
    check("reset_inside", InsideRectangle, 0);
    resetN = 1'b0;
    cycle();

    // Placement and rectangle hits
    playerX = 11'd70; playerY = 11'd100; placeReq = 1'b1;
    cycle();
    placeReq = 1'b0;
    check("place_armed", bombActive, 1);
    pixelX = 11'd80; pixelY = 11'd110;
    cycle();
    check("hit_inside", InsideRectangle, 1);
    check("hit_offx", offsetX, 16);
    check("hit_offy", offsetY, 14);
    pixelX = 11'd96; pixelY = 11'd96;
    cycle();
    check("miss_right_inside", InsideRectangle, 0);
    check("miss_right_offx", offsetX, 0);
    pixelX = 11'd63; pixelY = 11'd100;
    cycle();
    check("miss_left_inside", InsideRectangle, 0);
    check("miss_left_offy", offsetY, 0);

    // Natural fuse expiry
    n = 0; seen = 1'b0;
    for (int i = 0; i < FUSE + 5 && !seen; i++) begin
      sof_cycle();
      n++;
      if (explodePulse) seen = 1'b1;
      else cycle();
    end
    check("fuse_frames", n, FUSE);
    check("blast_on", blastActive, 1);
    check("blast_x", blastX, 64);
    check("blast_y", blastY, 96);
    placeReq = 1'b1;
    cycle();
    placeReq = 1'b0;
    check("explode_one_cycle", explodePulse, 0);
    check("place_ignored_in_blast", bombActive, 0);
    n = 0;
    for (int i = 0; i < BLAST + 5 && blastActive; i++) begin
      sof_cycle();
      n++;
    end
    check("blast_frames", n, BLAST);
    check("idle_after_blast", blastActive, 0);

    // Chain trigger ignored in IDLE, effective mid-fuse
    chainTrigger = 1'b1;
    cycle();
    chainTrigger = 1'b0;
    check("chain_idle_blast", blastActive, 0);
    check("chain_idle_bomb", bombActive, 0);
    placeReq = 1'b1;
    cycle();
    placeReq = 1'b0;
    for (int i = 0; i < FUSE - 51; i++) sof_cycle();
    chainTrigger = 1'b1;
    cycle();
    chainTrigger = 1'b0;
    check("chain_blast", blastActive, 1);
    check("chain_explode", explodePulse, 1);
    for (int i = 0; i < BLAST; i++) sof_cycle();
    check("chain_back_idle", blastActive, 0);

    // Asynchronous reset mid-fuse
    placeReq = 1'b1;
    cycle();
    placeReq = 1'b0;
    pixelX = 11'd80; pixelY = 11'd110;
    sof_cycle(); sof_cycle();
    @(posedge clk);
    #3 resetN = 1'b1;
    #1;
    check("async_bomb_active", bombActive, 0);
    check("async_inside", InsideRectangle, 0);
    check("async_offx", offsetX, 0);
    @(negedge clk);
    resetN = 1'b0;
    playerX = 11'd300; playerY = 11'd500; placeReq = 1'b1;
    cycle();
    placeReq = 1'b0;
    check("replace_armed", bombActive, 1);
    pixelX = 11'd300; pixelY = 11'd520;
    cycle();
    check("replace_inside", InsideRectangle, 1);
    check("replace_offx", offsetX, 12);
    check("replace_offy", offsetY, 8);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk);
        #3 resetN = 1'b1;
        @(negedge clk);
        resetN = 1'b0;
      end
      startOfFrame = ($urandom_range(0, 3) == 0);
      placeReq     = ($urandom_range(0, 7) == 0);
      chainTrigger = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) begin
        playerX = 11'($urandom_range(1990, 2047));
        playerY = 11'($urandom_range(1990, 2047));
      end else begin
        playerX = 11'($urandom_range(0, 2047));
        playerY = 11'($urandom_range(0, 2047));
      end
      if ($urandom_range(0, 4) == 0) begin
        pixelX = 11'($urandom_range(0, 2047));
        pixelY = 11'($urandom_range(0, 2047));
      end else begin
        pixelX = 11'(m_bx + $urandom_range(0, 44) - 6);
        pixelY = 11'(m_by + $urandom_range(0, 44) - 6);
      end
      cycle();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bomb_object.md
BOMB_OBJECT -- requirements
Module: bomb_object

Interface
REQ-001 Parameter FUSE_FRAMES, default 120, frames from placement to explosion (range 1..1023).
REQ-002 Parameter BLAST_FRAMES, default 30, frames the blast stays active (range 1..1023).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 resetN  in  1  asynchronous reset, active-high (asserted when 1, despite the name).
REQ-005 startOfFrame  in  1  one-cycle pulse, once per video frame.
REQ-006 pixelX, pixelY  in  11 each  current scan pixel coordinate.
REQ-007 playerX, playerY  in  11 each  player top-left coordinate.
REQ-008 placeReq  in  1  request to drop a bomb, level or pulse.
REQ-009 chainTrigger  in  1  external blast hit this bomb; forces early explosion.
REQ-010 offsetX, offsetY  out  11 each  pixel offset inside the 32x32 bomb square, for the bomb bitmap.
REQ-011 InsideRectangle  out  1  current pixel lies inside the armed bomb square.
REQ-012 bombActive  out  1  bomb is armed (fuse running).
REQ-013 blastActive  out  1  blast phase in progress.
REQ-014 blastX, blastY  out  11 each  top-left of the exploded square, stable while blastActive.
REQ-015 explodePulse  out  1  one-cycle pulse at the ARMED->BLAST transition.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED, BLAST.
REQ-017 In IDLE with placeReq=1, the next edge SHALL latch bombX={(playerX+16)[10:5],5'b0}, bombY likewise, load fuse=FUSE_FRAMES-1, enter ARMED.
REQ-018 placeReq SHALL be ignored in ARMED and BLAST; a single bomb exists at a time.
REQ-019 In ARMED, fuse SHALL decrement by 1 on each startOfFrame; startOfFrame with fuse=0 SHALL cause ARMED->BLAST.
REQ-020 chainTrigger=1 in ARMED SHALL cause ARMED->BLAST on the next edge regardless of fuse; chainTrigger SHALL be ignored in IDLE and BLAST.
REQ-021 On ARMED->BLAST, explodePulse SHALL be 1 for exactly one cycle, blastX/blastY SHALL take bombX/bombY, and the counter SHALL load BLAST_FRAMES-1.
REQ-022 In BLAST, the counter SHALL decrement on each startOfFrame; startOfFrame with counter=0 SHALL cause BLAST->IDLE.
REQ-023 Simultaneous chainTrigger and startOfFrame with fuse=0 SHALL produce one transition and one explodePulse.
REQ-024 InsideRectangle, offsetX and offsetY SHALL be registered: one-cycle latency from pixelX/pixelY.
REQ-025 InsideRectangle SHALL be 1 iff state is ARMED and bombX<=pixelX<bombX+32 and bombY<=pixelY<bombY+32.
REQ-026 offsetX=pixelX-bombX and offsetY=pixelY-bombY (11-bit) when inside; both SHALL be 0 otherwise.
REQ-027 Comparisons SHALL use 12-bit unsigned arithmetic so bombX+32 does not wrap at 2047.
REQ-028 bombActive=(state==ARMED) and blastActive=(state==BLAST), driven from registered state.

Reset
REQ-029 On resetN=1, regardless of clock and mid-fuse or mid-blast: state=IDLE, counters=0, bombX/Y=0, blastX/Y=0; all outputs 0.
REQ-030 After resetN deasserts, the first placeReq SHALL be honoured on the next edge.

Configuration
REQ-031 Macro BOMB_BLINK_EN: when defined, InsideRectangle SHALL be forced to 0 when fuse<32 and an internal frame counter bit 2 is 1 (4-frame blink); when undefined, the bomb is drawn steadily for the whole fuse.

Structure
REQ-032 Package bomb_pkg SHALL hold the state enum (IDLE, ARMED, BLAST), OBJECT_SIZE=32, and the FUSE_FRAMES/BLAST_FRAMES defaults.
REQ-033 Sub-module bomb_frame_counter (10-bit loadable down-counter, enabled by startOfFrame, zero flag) SHALL be instantiated once and shared by the ARMED and BLAST phases.

Verification
REQ-034 playerX=70, playerY=100, placeReq pulse -> bombX=64, bombY=96; ARMED next cycle; pixel (80,110) -> one cycle later InsideRectangle=1, offset=(16,14).
REQ-035 Pixel (96,96) or (63,100) while ARMED -> InsideRectangle=0, offset=(0,0).
REQ-036 FUSE_FRAMES=3: after placement, the 3rd startOfFrame -> explodePulse for 1 cycle, blastActive=1, blastX/Y=(64,96); BLAST_FRAMES=2 -> IDLE after 2 more frames.
REQ-037 chainTrigger at fuse=50 -> BLAST next cycle; placeReq during BLAST ignored; chainTrigger in IDLE -> no change.
REQ-038 resetN asserted mid-ARMED, asynchronously between edges -> all outputs 0 immediately; placeReq after release -> new bomb latched.
REQ-039 With BOMB_BLINK_EN, fuse<32 -> InsideRectangle alternates every 4 frames; without it -> steady 1 for in-square pixels.
